// File: rtl/axi4_write_master_if.sv
// Bundle of the client command/beat signals and the AXI4 AW/W/B channels seen by axi4_write_master.
// The master modport is the write engine's view; the slave modport is the client plus memory side.
interface axi4_write_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        done;
    logic [1:0]  done_resp;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WLAST;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, wr_data, wr_valid, AWREADY, WREADY, BRESP, BVALID,
        output cmd_ready, wr_ready, done, done_resp, AWADDR, AWLEN, AWSIZE, AWVALID,
               WDATA, WVALID, WLAST, BREADY
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, wr_data, wr_valid, AWREADY, WREADY, BRESP, BVALID,
        input  cmd_ready, wr_ready, done, done_resp, AWADDR, AWLEN, AWSIZE, AWVALID,
               WDATA, WVALID, WLAST, BREADY
    );
endinterface

// File: rtl/axi4_write_master.sv
// AXI4 write initiator: one INCR burst of 4-byte beats at a time, IDLE->ADDR->DATA->RESP.
// Define AXI4_WM_TIMEOUT_EN to force completion (resp 2'b11) after TIMEOUT_CYC cycles without BVALID.
module axi4_write_master
`ifdef AXI4_WM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 1024
)
`endif
(
    input  logic                ACLK,
    input  logic                ARESET,
    axi4_write_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t     state;
    logic [8:0] loaded;
    logic       wr_fire;
    logic       w_fire;

`ifdef AXI4_WM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] resp_cnt;
`endif

    // A client beat may enter the single output register only when it is empty or draining this cycle.
    assign bus.wr_ready = (state == DATA) && (loaded <= {1'b0, bus.AWLEN}) &&
                          (!bus.WVALID || bus.WREADY);
    assign wr_fire      = bus.wr_valid && bus.wr_ready;
    assign w_fire       = bus.WVALID && bus.WREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state         <= IDLE;
            loaded        <= '0;
            bus.cmd_ready <= 1'b0;
            bus.done      <= 1'b0;
            bus.done_resp <= 2'b00;
            bus.AWADDR    <= '0;
            bus.AWLEN     <= '0;
            bus.AWSIZE    <= 3'b000;
            bus.AWVALID   <= 1'b0;
            bus.WDATA     <= '0;
            bus.WVALID    <= 1'b0;
            bus.WLAST     <= 1'b0;
            bus.BREADY    <= 1'b0;
`ifdef AXI4_WM_TIMEOUT_EN
            resp_cnt      <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b1;
                    end else if (bus.cmd_valid) begin
                        bus.cmd_ready <= 1'b0;
                        bus.AWADDR    <= {bus.cmd_addr[15:2], 2'b00};
                        bus.AWLEN     <= bus.cmd_len;
                        bus.AWSIZE    <= 3'b010;
                        bus.AWVALID   <= 1'b1;
                        loaded        <= '0;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.AWREADY) begin
                        bus.AWVALID <= 1'b0;
                        bus.AWSIZE  <= 3'b000;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    // The final beat can never coincide with a load, since loaded has passed AWLEN.
                    if (w_fire && bus.WLAST) begin
                        bus.WVALID <= 1'b0;
                        bus.WLAST  <= 1'b0;
                        bus.BREADY <= 1'b1;
                        state      <= RESP;
`ifdef AXI4_WM_TIMEOUT_EN
                        resp_cnt   <= '0;
`endif
                    end else if (wr_fire) begin
                        bus.WDATA  <= bus.wr_data;
                        bus.WVALID <= 1'b1;
                        bus.WLAST  <= (loaded == {1'b0, bus.AWLEN});
                        loaded     <= loaded + 9'd1;
                    end else if (w_fire) begin
                        bus.WVALID <= 1'b0;
                    end
                end
                RESP: begin
                    if (bus.BVALID) begin
                        bus.BREADY    <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.done_resp <= bus.BRESP;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
`ifdef AXI4_WM_TIMEOUT_EN
                    end else if (resp_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        bus.BREADY    <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.done_resp <= 2'b11;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        resp_cnt      <= resp_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_write_master.sv
// Directed bench for axi4_write_master: client beats are queued as expected W beats and
// matched against the W channel; covers stalls, gaps, long bursts, mid-burst reset and RESP wait.
module tb_axi4_write_master;

    localparam int TIMEOUT_TB = 16;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic  ACLK   = 1'b0;
    logic  ARESET = 1'b1;
    int    checks = 0;
    int    errors = 0;
    int    beat_count = 0;
    int    done_count = 0;
    beat_t exp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    axi4_write_master_if bus ();

`ifdef AXI4_WM_TIMEOUT_EN
    axi4_write_master #(.TIMEOUT_CYC(TIMEOUT_TB)) dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));
`else
    axi4_write_master dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));
`endif

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outputsVector();
        return {19'd0, bus.cmd_ready, bus.wr_ready, bus.done, bus.done_resp, bus.AWVALID,
                bus.WVALID, bus.WLAST, bus.BREADY, |bus.AWADDR, |bus.AWLEN, |bus.AWSIZE, |bus.WDATA};
    endfunction

    // W-channel monitor: pops the scoreboard on every beat handshake and checks stall stability.
    always @(negedge ACLK) begin
        if (ARESET) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("w held valid", {31'd0, bus.WVALID}, 32'd1);
                checkOutput("w held data", bus.WDATA, prev_data);
                checkOutput("w held last", {31'd0, bus.WLAST}, {31'd0, prev_last});
            end
            if (bus.WVALID && bus.WREADY) begin
                checkOutput("beat expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    checkOutput("beat data", bus.WDATA, e.data);
                    checkOutput("beat last", {31'd0, bus.WLAST}, {31'd0, e.last});
                end
                beat_count <= beat_count + 1;
            end
            if (bus.done) done_count <= done_count + 1;
            prev_stall <= bus.WVALID && !bus.WREADY;
            prev_data  <= bus.WDATA;
            prev_last  <= bus.WLAST;
        end
    end

    task automatic feedBeats(input int n, input logic [31:0] base, input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 4000) begin
            bus.wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.wr_data  = base + 32'(i);
            @(negedge ACLK);
            if (bus.wr_valid && bus.wr_ready) begin
                exp_q.push_back('{data: base + 32'(i), last: (i == n - 1)});
                i++;
            end
            @(posedge ACLK); #1;
            guard++;
        end
        bus.wr_valid = 1'b0;
        checkOutput("feed complete", i, n);
    endtask

    task automatic driveWready(input int mode);
        int guard = 0;
        while (!bus.BREADY && guard < 4000) begin
            case (mode)
                0:       bus.WREADY = 1'b1;
                1:       bus.WREADY = ~bus.WREADY;
                default: bus.WREADY = 1'($urandom_range(0, 1));
            endcase
            @(posedge ACLK); #1;
            guard++;
        end
        bus.WREADY = 1'b0;
        checkOutput("reached RESP", {31'd0, bus.BREADY}, 32'd1);
    endtask

    task automatic issueCmd(input logic [15:0] addr, input logic [7:0] len, input int awdelay);
        int guard = 0;
        logic [15:0] exp_addr;
        exp_addr      = addr & 16'hFFFC;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        @(negedge ACLK);
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge ACLK);
            guard++;
        end
        checkOutput("cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(posedge ACLK); #1;
        bus.cmd_valid = 1'b0;
        checkOutput("AWVALID", {31'd0, bus.AWVALID}, 32'd1);
        checkOutput("AWADDR", {16'd0, bus.AWADDR}, {16'd0, exp_addr});
        checkOutput("AWLEN", {24'd0, bus.AWLEN}, {24'd0, len});
        checkOutput("AWSIZE", {29'd0, bus.AWSIZE}, 32'd2);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hBAD0BAD0;
        for (int k = 0; k < awdelay; k++) begin
            @(posedge ACLK); #1;
            checkOutput("AW held valid", {31'd0, bus.AWVALID}, 32'd1);
            checkOutput("AW held addr", {16'd0, bus.AWADDR}, {16'd0, exp_addr});
            checkOutput("no WVALID before AW", {31'd0, bus.WVALID}, 32'd0);
            checkOutput("wr_ready low before AW", {31'd0, bus.wr_ready}, 32'd0);
        end
        bus.wr_valid = 1'b0;
        bus.AWREADY  = 1'b1;
        @(posedge ACLK); #1;
        bus.AWREADY  = 1'b0;
        checkOutput("AWVALID dropped", {31'd0, bus.AWVALID}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] len, input logic [31:0] base,
                                 input int wmode, input bit gaps, input int awdelay, input logic [1:0] bresp);
        int n = int'(len) + 1;
        int start_beats = beat_count;
        int start_done  = done_count;
        issueCmd(addr, len, awdelay);
        fork
            feedBeats(n, base, gaps);
            driveWready(wmode);
        join
        bus.BRESP  = bresp;
        bus.BVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.BVALID = 1'b0;
        bus.BRESP  = 2'b00;
        checkOutput("done pulse", {31'd0, bus.done}, 32'd1);
        checkOutput("done_resp", {30'd0, bus.done_resp}, {30'd0, bresp});
        checkOutput("BREADY dropped", {31'd0, bus.BREADY}, 32'd0);
        @(posedge ACLK); #1;
        checkOutput("done single cycle", {31'd0, bus.done}, 32'd0);
        checkOutput("cmd_ready after done", {31'd0, bus.cmd_ready}, 32'd1);
        checkOutput("beat count", beat_count - start_beats, n);
        checkOutput("scoreboard drained", exp_q.size(), 32'd0);
        checkOutput("done count", done_count - start_done, 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int i;
        int guard;
        int start_beats;
        int start_done;
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        bus.AWREADY   = 1'b0;
        bus.WREADY    = 1'b0;
        bus.BRESP     = 2'b00;
        bus.BVALID    = 1'b0;

        repeat (2) @(posedge ACLK);
        #1;
        checkOutput("outputs zero in reset", outputsVector(), 32'd0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        checkOutput("cmd_ready after reset", {31'd0, bus.cmd_ready}, 32'd1);

        $display("[TB] single beat, unaligned address");
        applyStimulus(16'h0013, 8'd0, 32'hDEADBEEF, 0, 1'b0, 0, 2'b00);

        $display("[TB] len 3, WREADY toggling");
        applyStimulus(16'h0040, 8'd3, 32'h00000001, 1, 1'b0, 0, 2'b00);

        $display("[TB] AWREADY low 10 cycles, gaps, random WREADY");
        applyStimulus(16'h1236, 8'd5, 32'hC0DE0000, 2, 1'b1, 10, 2'b01);

        $display("[TB] len 255 streaming");
        applyStimulus(16'h8000, 8'd255, 32'h10000000, 0, 1'b0, 0, 2'b00);

        $display("[TB] reset after beat 2 of len 7");
        issueCmd(16'h0100, 8'd7, 0);
        start_beats = beat_count;
        start_done  = done_count;
        bus.WREADY  = 1'b1;
        i = 0;
        guard = 0;
        while (beat_count - start_beats < 2 && guard < 50) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'h77000000 + 32'(i);
            @(negedge ACLK);
            if (bus.wr_ready) begin
                exp_q.push_back('{data: 32'h77000000 + 32'(i), last: (i == 7)});
                i++;
            end
            @(posedge ACLK); #1;
            guard++;
        end
        checkOutput("two beats before reset", beat_count - start_beats, 32'd2);
        ARESET = 1'b1;
        #1;
        checkOutput("outputs zero on mid-burst reset", outputsVector(), 32'd0);
        bus.wr_valid = 1'b0;
        bus.WREADY   = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("no done across reset", done_count - start_done, 32'd0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        checkOutput("cmd_ready after mid reset", {31'd0, bus.cmd_ready}, 32'd1);
        applyStimulus(16'h0200, 8'd1, 32'hA5A50000, 0, 1'b0, 0, 2'b00);

        $display("[TB] no BVALID in RESP, top address");
        start_done = done_count;
        issueCmd(16'hFFFF, 8'd0, 0);
        fork
            feedBeats(1, 32'h12345678, 1'b0);
            driveWready(0);
        join
`ifdef AXI4_WM_TIMEOUT_EN
        n = 0;
        while (!bus.done && n < 200) begin
            @(posedge ACLK); #1;
            n++;
        end
        checkOutput("timeout cycles", n, TIMEOUT_TB);
        checkOutput("timeout done", {31'd0, bus.done}, 32'd1);
        checkOutput("timeout resp", {30'd0, bus.done_resp}, 32'd3);
        @(posedge ACLK); #1;
        checkOutput("cmd_ready after timeout", {31'd0, bus.cmd_ready}, 32'd1);
`else
        n = 0;
        repeat (40) begin
            @(posedge ACLK); #1;
            n++;
        end
        checkOutput("waited in RESP", n, 32'd40);
        checkOutput("no done without BVALID", done_count - start_done, 32'd0);
        checkOutput("BREADY held in RESP", {31'd0, bus.BREADY}, 32'd1);
        bus.BRESP  = 2'b10;
        bus.BVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.BVALID = 1'b0;
        checkOutput("late done", {31'd0, bus.done}, 32'd1);
        checkOutput("late done_resp", {30'd0, bus.done_resp}, 32'd2);
`endif
        checkOutput("scoreboard empty at end", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
